// File: rtl/pid_hdng.sv
// pid_hdng: heading PID controller feeding the motor driver.
//
// Each accepted heading sample yields a signed steering correction. The
// correction is added to the forward-speed command for the left wheel and
// subtracted from it for the right wheel.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset, clears every register
//   moving     1 = loop active; 0 = outputs zeroed and loop state cleared
//   hdng_vld   single-cycle strobe qualifying dsrd_hdng/actl_hdng
//   dsrd_hdng  desired heading, 12-bit unsigned circular
//   actl_hdng  measured heading, 12-bit unsigned circular
//   frwrd_spd  11-bit unsigned forward speed command
//   lft_spd    signed 12-bit left motor speed
//   rght_spd   signed 12-bit right motor speed
//   at_hdng    registered flag: |heading error| < AT_HDNG_THRESH
//
// Latency is 3 clocks from hdng_vld to lft_spd/rght_spd. The pipeline accepts
// one sample per clock.
module pid_hdng #(
    parameter logic [3:0]  P_COEFF        = 4'd3,
    parameter logic [3:0]  D_COEFF        = 4'd6,
    parameter int unsigned AT_HDNG_THRESH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               moving,
    input  logic               hdng_vld,
    input  logic [11:0]        dsrd_hdng,
    input  logic [11:0]        actl_hdng,
    input  logic [10:0]        frwrd_spd,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               at_hdng
);

    localparam logic [10:0] THRESH = 11'(AT_HDNG_THRESH);

    function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
        if (v > 12'sd511)       return 10'b01_1111_1111;
        else if (v < -12'sd512) return 10'b10_0000_0000;
        else                    return v[9:0];
    endfunction

    function automatic logic signed [6:0] sat7(input logic signed [10:0] v);
        if (v > 11'sd63)       return 7'b011_1111;
        else if (v < -11'sd64) return 7'b100_0000;
        else                   return v[6:0];
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)       return 16'h7FFF;
        else if (v < -17'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction

    function automatic logic signed [13:0] sat14(input logic signed [15:0] v);
        if (v > 16'sd8191)       return 14'h1FFF;
        else if (v < -16'sd8192) return 14'h2000;
        else                     return v[13:0];
    endfunction

    function automatic logic signed [11:0] sat12(input logic signed [14:0] v);
        if (v > 15'sd2047)       return 12'h7FF;
        else if (v < -15'sd2048) return 12'h800;
        else                     return v[11:0];
    endfunction

    // Control registers
    logic               r_vld_p1;
    logic               r_vld_p2;
    logic               r_at_hdng;
    // Datapath and loop state
    logic signed [9:0]  r_err_p1;
    logic signed [9:0]  r_prev_err;
    logic signed [15:0] r_integ;
    logic signed [13:0] r_pid_p2;
    logic signed [11:0] r_lft_p3;
    logic signed [11:0] r_rght_p3;

    // ---- Stage 1: circular heading error ----
    // Modulo-4096 subtraction read as signed picks the shortest way round.
    logic [11:0]        w_diff_u;
    logic signed [11:0] w_raw;
    logic signed [9:0]  w_err_sat;
    logic signed [10:0] w_err_ext;
    logic [10:0]        w_err_abs;
    logic               w_at;

    assign w_diff_u  = actl_hdng - dsrd_hdng;
    assign w_raw     = $signed(w_diff_u);
    assign w_err_sat = sat10(w_raw);
    assign w_err_ext = {w_err_sat[9], w_err_sat};
    assign w_err_abs = w_err_ext[10] ? -w_err_ext : w_err_ext;
    assign w_at      = (w_err_abs < THRESH);

    // ---- Stage 2: integrator, derivative, PID sum ----
    logic signed [16:0] w_integ_sum;
    logic signed [15:0] w_integ_next;
    logic signed [10:0] w_d_raw;
    logic signed [6:0]  w_d_sat;
    logic signed [15:0] w_p_term;
    logic signed [15:0] w_i_term;
    logic signed [15:0] w_d_term;
    logic signed [15:0] w_pid_sum;

    assign w_integ_sum  = {r_integ[15], r_integ} + {{7{r_err_p1[9]}}, r_err_p1};
    assign w_integ_next = sat16(w_integ_sum);
    assign w_d_raw      = {r_err_p1[9], r_err_p1} - {r_prev_err[9], r_prev_err};
    assign w_d_sat      = sat7(w_d_raw);
    assign w_p_term     = $signed({{6{r_err_p1[9]}}, r_err_p1}) * $signed({12'd0, P_COEFF});
    // The I term uses the freshly updated integrator, not the stored one.
    assign w_i_term     = w_integ_next >>> 6;
    assign w_d_term     = $signed({{9{w_d_sat[6]}}, w_d_sat}) * $signed({12'd0, D_COEFF});
    assign w_pid_sum    = w_p_term + w_i_term + w_d_term;

    // ---- Stage 3: differential wheel speeds ----
    logic signed [13:0] w_corr;
    logic signed [14:0] w_lft_sum;
    logic signed [14:0] w_rght_sum;

    assign w_corr     = r_pid_p2 >>> 3;
    assign w_lft_sum  = $signed({4'd0, frwrd_spd}) + $signed({w_corr[13], w_corr});
    assign w_rght_sum = $signed({4'd0, frwrd_spd}) - $signed({w_corr[13], w_corr});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_at_hdng  <= 1'b0;
            r_err_p1   <= '0;
            r_prev_err <= '0;
            r_integ    <= '0;
            r_pid_p2   <= '0;
            r_lft_p3   <= '0;
            r_rght_p3  <= '0;
        end else if (!moving) begin
            // Dropping the valids discards any in-flight sample.
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_at_hdng  <= 1'b0;
            r_prev_err <= '0;
            r_integ    <= '0;
            r_lft_p3   <= '0;
            r_rght_p3  <= '0;
        end else begin
            r_vld_p1 <= hdng_vld;
            if (hdng_vld) begin
                r_err_p1  <= w_err_sat;
                r_at_hdng <= w_at;
            end
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_integ    <= w_integ_next;
                r_prev_err <= r_err_p1;
                r_pid_p2   <= sat14(w_pid_sum);
            end
            if (r_vld_p2) begin
                r_lft_p3  <= sat12(w_lft_sum);
                r_rght_p3 <= sat12(w_rght_sum);
            end
        end
    end

    assign lft_spd  = r_lft_p3;
    assign rght_spd = r_rght_p3;
    assign at_hdng  = r_at_hdng;

endmodule

// File: tb/tb_pid_hdng.sv
// tb_pid_hdng: self-checking bench for pid_hdng.
// An integer-arithmetic reference model predicts the outputs; a negedge
// process compares the DUT against it on every cycle. Directed vectors add
// hand-computed literal expectations.
module tb_pid_hdng;

    logic               clk;
    logic               rst;
    logic               moving;
    logic               hdng_vld;
    logic [11:0]        dsrd_hdng;
    logic [11:0]        actl_hdng;
    logic [10:0]        frwrd_spd;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               at_hdng;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    pid_hdng dut (
        .clk       (clk),
        .rst       (rst),
        .moving    (moving),
        .hdng_vld  (hdng_vld),
        .dsrd_hdng (dsrd_hdng),
        .actl_hdng (actl_hdng),
        .frwrd_spd (frwrd_spd),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .at_hdng   (at_hdng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int P = 3;
    localparam int D = 6;
    localparam int THR = 10;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int floordiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    typedef struct {
        int corr;
        int left;
    } pend_t;

    pend_t mq[$];
    int m_integ = 0;
    int m_prev  = 0;
    int m_lft   = 0;
    int m_rght  = 0;
    int m_at    = 0;

    always @(posedge clk) begin : model
        int raw, err, diff, pid, fs;
        pend_t p;
        if (rst || !moving) begin
            m_integ = 0; m_prev = 0; m_lft = 0; m_rght = 0; m_at = 0;
            mq.delete();
        end else begin
            fs = int'(frwrd_spd);
            foreach (mq[i]) mq[i].left = mq[i].left - 1;
            while (mq.size() > 0 && mq[0].left == 0) begin
                m_lft  = clamp(fs + mq[0].corr, -2048, 2047);
                m_rght = clamp(fs - mq[0].corr, -2048, 2047);
                mq.delete(0);
            end
            if (hdng_vld) begin
                raw = (int'(actl_hdng) - int'(dsrd_hdng) + 4096) % 4096;
                if (raw >= 2048) raw = raw - 4096;
                err     = clamp(raw, -512, 511);
                m_at    = ((err < 0 ? -err : err) < THR) ? 1 : 0;
                m_integ = clamp(m_integ + err, -32768, 32767);
                diff    = clamp(err - m_prev, -64, 63);
                m_prev  = err;
                pid     = clamp(err * P + floordiv(m_integ, 64) + diff * D, -8192, 8191);
                p.corr  = floordiv(pid, 8);
                p.left  = 2;
                mq.push_back(p);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_lft", lft_spd, m_lft);
            check("cyc_rght", rght_spd, m_rght);
            check("cyc_at", at_hdng, m_at);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] d, input logic [11:0] a);
        dsrd_hdng = d;
        actl_hdng = a;
        hdng_vld  = 1'b1;
        step();
        hdng_vld  = 1'b0;
    endtask

    task automatic restart();
        moving = 1'b0;
        step();
        moving = 1'b1;
    endtask

    initial begin
        rst = 1'b1; moving = 1'b1; hdng_vld = 1'b0;
        dsrd_hdng = '0; actl_hdng = '0; frwrd_spd = '0;
        step();
        cmp_en = 1;

        // Reset held with strobes pulsing
        frwrd_spd = 11'd512;
        actl_hdng = 12'd5; hdng_vld = 1'b1; step();
        hdng_vld = 1'b0; step();
        hdng_vld = 1'b1; step();
        check("rst_lft", lft_spd, 0);
        check("rst_at", at_hdng, 0);
        rst = 1'b0; hdng_vld = 1'b0; step();
        check("rel_lft", lft_spd, 0);
        check("rel_rght", rght_spd, 0);
        check("rel_at", at_hdng, 0);

        // Basic step: err = +100
        restart();
        strobe(12'h000, 12'h064);
        check("basic_at", at_hdng, 0);
        step();
        check("basic_lat", lft_spd, 0);
        step();
        check("basic_lft", lft_spd, 596);
        check("basic_rght", rght_spd, 428);
        step(); step();
        check("basic_hold", lft_spd, 596);

        // Wrap-around: 0xFF0 -> 0x010 is +32
        restart();
        frwrd_spd = 11'd0;
        strobe(12'hFF0, 12'h010);
        step(); step();
        check("wrap_lft", lft_spd, 36);
        check("wrap_rght", rght_spd, -36);

        // Saturation
        restart();
        frwrd_spd = 11'h7FF;
        strobe(12'h000, 12'h600);
        step(); step();
        check("sat_lft", lft_spd, 2047);
        check("sat_rght", rght_spd, 1808);

        // Integrator clamp
        restart();
        frwrd_spd = 11'd0;
        for (int i = 1; i <= 70; i++) begin
            strobe(12'h000, 12'h1FF);
            if (i == 64) check("integ_64", m_integ, 32704);
            if (i == 65) check("integ_65", m_integ, 32767);
        end
        step(); step();
        check("clamp_lft", lft_spd, 255);
        check("clamp_rght", rght_spd, -255);
        strobe(12'h000, 12'h000);
        strobe(12'h000, 12'h000);
        strobe(12'h000, 12'h000);
        step(); step();
        check("hold_integ", m_integ, 32767);
        check("hold_lft", lft_spd, 63);
        check("hold_rght", rght_spd, -63);

        // at_hdng threshold boundaries
        strobe(12'h000, 12'h005);
        check("at_p5", at_hdng, 1);
        strobe(12'h000, 12'h00A);
        check("at_p10", at_hdng, 0);
        strobe(12'h00A, 12'h001);
        check("at_m9", at_hdng, 1);
        strobe(12'h000, 12'hFF6);
        check("at_m10", at_hdng, 0);
        step(); step();

        // moving dropped with a sample in flight
        restart();
        frwrd_spd = 11'd512;
        strobe(12'h000, 12'h064);
        step(); step();
        check("drop_pre", lft_spd, 596);
        strobe(12'h000, 12'h064);
        moving = 1'b0;
        step();
        check("drop_lft", lft_spd, 0);
        check("drop_rght", rght_spd, 0);
        moving = 1'b1;
        step(); step(); step();
        check("drop_nolate", lft_spd, 0);
        strobe(12'h000, 12'h064);
        step(); step();
        check("drop_re_lft", lft_spd, 596);
        check("drop_re_rght", rght_spd, 428);

        // Back-to-back mixed samples
        frwrd_spd = 11'd1000;
        strobe(12'h100, 12'h000);
        strobe(12'h800, 12'h000);
        strobe(12'h000, 12'h7FF);
        strobe(12'h123, 12'h130);
        strobe(12'h000, 12'h000);
        step(); step(); step();

        // Random traffic, occasional moving drops
        for (int i = 0; i < 200; i++) begin
            dsrd_hdng = 12'($urandom);
            actl_hdng = 12'($urandom);
            frwrd_spd = 11'($urandom);
            hdng_vld  = ($urandom_range(0, 3) != 0);
            moving    = ($urandom_range(0, 15) != 0);
            step();
        end
        moving = 1'b1; hdng_vld = 1'b0;
        step(); step(); step();

        // Reset mid-operation has priority
        frwrd_spd = 11'd512;
        strobe(12'h000, 12'h064);
        step(); step();
        rst = 1'b1; hdng_vld = 1'b1;
        step();
        check("mrst_lft", lft_spd, 0);
        check("mrst_at", at_hdng, 0);
        rst = 1'b0; hdng_vld = 1'b0;
        step(); step();

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
